// File: rtl/imm_gen_pipe.sv
// Registered ready/valid immediate-generation stage for the decode path.
// Decodes RV32I/RV64I immediates, sign-extends to XLEN and flags illegal opcodes.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int SKID  = 1,
    parameter int TAG_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [31:0]      i_in_ins,
    input  logic [TAG_W-1:0] i_in_tag,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [XLEN-1:0]  o_out_imm,
    output logic [2:0]       o_out_fmt,
    output logic             o_out_illegal,
    output logic [TAG_W-1:0] o_out_tag,
    output logic [15:0]      o_illegal_cnt
);

    localparam logic [2:0] FMT_R     = 3'd0;
    localparam logic [2:0] FMT_I     = 3'd1;
    localparam logic [2:0] FMT_S     = 3'd2;
    localparam logic [2:0] FMT_B     = 3'd3;
    localparam logic [2:0] FMT_U     = 3'd4;
    localparam logic [2:0] FMT_J     = 3'd5;
    localparam logic [2:0] FMT_SHAMT = 3'd6;
    localparam logic [2:0] FMT_ILL   = 3'd7;

    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_ONE,
        ST_FULL
    } state_t;

    logic [6:0]        w_opcode;
    logic [2:0]        w_funct3;
    logic              w_shamt_hi;
    logic signed [31:0] w_imm32;
    logic [XLEN-1:0]   w_imm;
    logic [2:0]        w_fmt;
    logic              w_ill;

    state_t            r_state;
    state_t            w_state_next;
    logic              w_in_ready;
    logic              w_in_fire;
    logic              w_out_fire;
    logic              w_load_out;
    logic              w_load_skid;
    logic              w_skid_to_out;
    logic              w_out_valid_next;

    logic              r_out_valid;
    logic [XLEN-1:0]   r_out_imm;
    logic [2:0]        r_out_fmt;
    logic              r_out_ill;
    logic [TAG_W-1:0]  r_out_tag;
    logic [XLEN-1:0]   r_skid_imm;
    logic [2:0]        r_skid_fmt;
    logic              r_skid_ill;
    logic [TAG_W-1:0]  r_skid_tag;
    logic [15:0]       r_illegal_cnt;

    assign w_opcode   = i_in_ins[6:0];
    assign w_funct3   = i_in_ins[14:12];
    assign w_shamt_hi = (XLEN == 64) ? i_in_ins[25] : 1'b0;

    // Every immediate is assembled as a signed 32-bit value; widening the
    // signed value then gives the XLEN=64 sign extension for free.
    always_comb begin
        w_imm32 = '0;
        w_fmt   = FMT_ILL;
        w_ill   = 1'b1;
        if (i_in_ins[1:0] == 2'b11) begin
            w_ill = 1'b0;
            case (w_opcode)
                OPC_OPIMM: begin
                    if (w_funct3 == 3'b001 || w_funct3 == 3'b101) begin
                        w_fmt   = FMT_SHAMT;
                        w_imm32 = {26'b0, w_shamt_hi, i_in_ins[24:20]};
                    end else begin
                        w_fmt   = FMT_I;
                        w_imm32 = {{20{i_in_ins[31]}}, i_in_ins[31:20]};
                    end
                end
                OPC_LOAD, OPC_JALR, OPC_SYSTEM: begin
                    w_fmt   = FMT_I;
                    w_imm32 = {{20{i_in_ins[31]}}, i_in_ins[31:20]};
                end
                OPC_STORE: begin
                    w_fmt   = FMT_S;
                    w_imm32 = {{20{i_in_ins[31]}}, i_in_ins[31:25], i_in_ins[11:7]};
                end
                OPC_BRANCH: begin
                    w_fmt   = FMT_B;
                    w_imm32 = {{19{i_in_ins[31]}}, i_in_ins[31], i_in_ins[7],
                               i_in_ins[30:25], i_in_ins[11:8], 1'b0};
                end
                OPC_LUI, OPC_AUIPC: begin
                    w_fmt   = FMT_U;
                    w_imm32 = {i_in_ins[31:12], 12'b0};
                end
                OPC_JAL: begin
                    w_fmt   = FMT_J;
                    w_imm32 = {{11{i_in_ins[31]}}, i_in_ins[31], i_in_ins[19:12],
                               i_in_ins[20], i_in_ins[30:21], 1'b0};
                end
                OPC_OP: begin
                    w_fmt = FMT_R;
                end
                default: begin
                    w_fmt = FMT_ILL;
                    w_ill = 1'b1;
                end
            endcase
        end
    end

    assign w_imm = XLEN'(w_imm32);

    assign w_in_ready = i_rst_n && ((SKID != 0) ? (r_state != ST_FULL)
                                                : (!r_out_valid || i_out_ready));
    assign w_in_fire  = i_in_valid && w_in_ready;
    assign w_out_fire = r_out_valid && i_out_ready;

    // In skid mode the second entry only fills when the output is stalled,
    // so in_ready depends on registered state alone.
    always_comb begin
        w_state_next     = r_state;
        w_load_out       = 1'b0;
        w_load_skid      = 1'b0;
        w_skid_to_out    = 1'b0;
        w_out_valid_next = r_out_valid;
        if (SKID != 0) begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_fire) begin
                        w_state_next = ST_ONE;
                        w_load_out   = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_in_fire && !w_out_fire) begin
                        w_state_next = ST_FULL;
                        w_load_skid  = 1'b1;
                    end else if (!w_in_fire && w_out_fire) begin
                        w_state_next = ST_EMPTY;
                    end else if (w_in_fire && w_out_fire) begin
                        w_load_out = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (w_out_fire) begin
                        w_state_next  = ST_ONE;
                        w_skid_to_out = 1'b1;
                    end
                end
                default: w_state_next = ST_EMPTY;
            endcase
            w_out_valid_next = (w_state_next != ST_EMPTY);
        end else begin
            w_load_out       = w_in_fire;
            w_out_valid_next = w_in_fire || (r_out_valid && !i_out_ready);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state       <= ST_EMPTY;
            r_out_valid   <= 1'b0;
            r_out_imm     <= '0;
            r_out_fmt     <= '0;
            r_out_ill     <= 1'b0;
            r_out_tag     <= '0;
            r_skid_imm    <= '0;
            r_skid_fmt    <= '0;
            r_skid_ill    <= 1'b0;
            r_skid_tag    <= '0;
            r_illegal_cnt <= '0;
        end else begin
            r_state     <= w_state_next;
            r_out_valid <= w_out_valid_next;
            if (w_load_out) begin
                r_out_imm <= w_imm;
                r_out_fmt <= w_fmt;
                r_out_ill <= w_ill;
                r_out_tag <= i_in_tag;
            end else if (w_skid_to_out) begin
                r_out_imm <= r_skid_imm;
                r_out_fmt <= r_skid_fmt;
                r_out_ill <= r_skid_ill;
                r_out_tag <= r_skid_tag;
            end
            if (w_load_skid) begin
                r_skid_imm <= w_imm;
                r_skid_fmt <= w_fmt;
                r_skid_ill <= w_ill;
                r_skid_tag <= i_in_tag;
            end
            if (w_in_fire && w_ill && (r_illegal_cnt != 16'hFFFF)) begin
                r_illegal_cnt <= r_illegal_cnt + 16'd1;
            end
        end
    end

    assign o_in_ready    = w_in_ready;
    assign o_out_valid   = r_out_valid;
    assign o_out_imm     = r_out_imm;
    assign o_out_fmt     = r_out_fmt;
    assign o_out_illegal = r_out_ill;
    assign o_out_tag     = r_out_tag;
    assign o_illegal_cnt = r_illegal_cnt;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: a 32-bit skid instance and a 64-bit
// single-register instance share one input stream and are checked against a reference decoder.
module tb_imm_gen_pipe;

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
        logic [7:0]  tag;
    } exp_t;

    logic        clk;
    logic        rstN;
    logic        inValid;
    logic [31:0] inIns;
    logic [7:0]  inTag;
    logic        readyA;
    logic        readyB;
    logic        wantReadyA;
    logic        wantReadyB;
    logic        randReady;

    logic        aInReady, aOutValid, aIll;
    logic [31:0] aImm;
    logic [2:0]  aFmt;
    logic [7:0]  aTag;
    logic [15:0] aCnt;
    logic        bInReady, bOutValid, bIll;
    logic [63:0] bImm;
    logic [2:0]  bFmt;
    logic [7:0]  bTag;
    logic [15:0] bCnt;

    exp_t        qA[$];
    exp_t        qB[$];
    exp_t        eA;
    exp_t        eB;
    logic [15:0] cntA;
    logic [15:0] cntB;
    int          checks;
    int          errors;

    imm_gen_pipe #(.XLEN(32), .SKID(1), .TAG_W(8)) dutA (
        .i_clk(clk), .i_rst_n(rstN), .i_in_valid(inValid), .o_in_ready(aInReady),
        .i_in_ins(inIns), .i_in_tag(inTag), .o_out_valid(aOutValid), .i_out_ready(readyA),
        .o_out_imm(aImm), .o_out_fmt(aFmt), .o_out_illegal(aIll), .o_out_tag(aTag),
        .o_illegal_cnt(aCnt)
    );

    imm_gen_pipe #(.XLEN(64), .SKID(0), .TAG_W(8)) dutB (
        .i_clk(clk), .i_rst_n(rstN), .i_in_valid(inValid), .o_in_ready(bInReady),
        .i_in_ins(inIns), .i_in_tag(inTag), .o_out_valid(bOutValid), .i_out_ready(readyB),
        .o_out_imm(bImm), .o_out_fmt(bFmt), .o_out_illegal(bIll), .o_out_tag(bTag),
        .o_illegal_cnt(bCnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #800000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decoder written with plain integer arithmetic on sign-extended words.
    function automatic exp_t refDecode(input logic [31:0] ins, input logic [7:0] tag, input int xlen);
        exp_t   e;
        longint s;
        longint t;
        s     = longint'($signed(ins));
        e.tag = tag;
        e.imm = 64'd0;
        e.fmt = 3'd7;
        e.ill = 1'b1;
        if (ins[1:0] == 2'b11) begin
            e.ill = 1'b0;
            case (ins[6:0])
                7'h13: begin
                    if (ins[13:12] == 2'b01) begin
                        e.fmt = 3'd6;
                        e.imm = (xlen == 64) ? 64'(ins[25:20]) : 64'(ins[24:20]);
                    end else begin
                        e.fmt = 3'd1;
                        t = s >>> 20;
                        e.imm = t;
                    end
                end
                7'h03, 7'h67, 7'h73: begin
                    e.fmt = 3'd1;
                    t = s >>> 20;
                    e.imm = t;
                end
                7'h23: begin
                    e.fmt = 3'd2;
                    t = s >>> 25;
                    e.imm = t * 32 + 64'(ins[11:7]);
                end
                7'h63: begin
                    e.fmt = 3'd3;
                    t = s >>> 31;
                    e.imm = t * 4096 + 64'(ins[7]) * 2048 + 64'(ins[30:25]) * 32 + 64'(ins[11:8]) * 2;
                end
                7'h37, 7'h17: begin
                    e.fmt = 3'd4;
                    e.imm = longint'($signed(ins & 32'hFFFFF000));
                end
                7'h6F: begin
                    e.fmt = 3'd5;
                    t = s >>> 31;
                    e.imm = t * 1048576 + 64'(ins[19:12]) * 4096 + 64'(ins[20]) * 2048 + 64'(ins[30:21]) * 2;
                end
                7'h33: e.fmt = 3'd0;
                default: begin
                    e.fmt = 3'd7;
                    e.ill = 1'b1;
                end
            endcase
        end
        if (xlen == 32) e.imm = {32'd0, e.imm[31:0]};
        return e;
    endfunction

    function automatic logic [31:0] randIns();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 12))
            0: w[6:0] = 7'h13;
            1: w[6:0] = 7'h03;
            2: w[6:0] = 7'h67;
            3: w[6:0] = 7'h73;
            4: w[6:0] = 7'h23;
            5: w[6:0] = 7'h63;
            6: w[6:0] = 7'h37;
            7: w[6:0] = 7'h17;
            8: w[6:0] = 7'h6F;
            9: w[6:0] = 7'h33;
            10: begin
                w[6:0]   = 7'h13;
                w[13:12] = 2'b01;
            end
            default: ;
        endcase
        return w;
    endfunction

    initial begin
        readyA = 1'b1;
        readyB = 1'b1;
        forever begin
            @(negedge clk);
            if (randReady) begin
                readyA = ($urandom_range(0, 3) != 0);
                readyB = ($urandom_range(0, 3) != 0);
            end else begin
                readyA = wantReadyA;
                readyB = wantReadyB;
            end
        end
    end

    // Monitor: one sample per cycle between edges; model transfers take effect at the next edge.
    always @(negedge clk) begin
        #1;
        if (!rstN) begin
            checkOutput("A.in_ready_in_reset", 64'(aInReady), 64'd0);
            checkOutput("B.in_ready_in_reset", 64'(bInReady), 64'd0);
            qA.delete();
            qB.delete();
            cntA = 16'd0;
            cntB = 16'd0;
        end else begin
            checkOutput("A.out_valid", 64'(aOutValid), 64'(qA.size() > 0));
            checkOutput("A.in_ready", 64'(aInReady), 64'(qA.size() < 2));
            checkOutput("A.illegal_cnt", 64'(aCnt), 64'(cntA));
            if (qA.size() > 0 && aOutValid) begin
                eA = qA[0];
                checkOutput("A.imm", 64'(aImm), eA.imm);
                checkOutput("A.fmt", 64'(aFmt), 64'(eA.fmt));
                checkOutput("A.illegal", 64'(aIll), 64'(eA.ill));
                checkOutput("A.tag", 64'(aTag), 64'(eA.tag));
                if (readyA) void'(qA.pop_front());
            end
            if (inValid && aInReady) begin
                eA = refDecode(inIns, inTag, 32);
                qA.push_back(eA);
                if (eA.ill && cntA != 16'hFFFF) cntA = cntA + 16'd1;
            end

            checkOutput("B.out_valid", 64'(bOutValid), 64'(qB.size() > 0));
            checkOutput("B.in_ready", 64'(bInReady), 64'((qB.size() == 0) || readyB));
            checkOutput("B.illegal_cnt", 64'(bCnt), 64'(cntB));
            if (qB.size() > 0 && bOutValid) begin
                eB = qB[0];
                checkOutput("B.imm", bImm, eB.imm);
                checkOutput("B.fmt", 64'(bFmt), 64'(eB.fmt));
                checkOutput("B.illegal", 64'(bIll), 64'(eB.ill));
                checkOutput("B.tag", 64'(bTag), 64'(eB.tag));
                if (readyB) void'(qB.pop_front());
            end
            if (inValid && bInReady) begin
                eB = refDecode(inIns, inTag, 64);
                qB.push_back(eB);
                if (eB.ill && cntB != 16'hFFFF) cntB = cntB + 16'd1;
            end
        end
    end

    // Holds one instruction valid until the skid instance takes it.
    task automatic applyStimulus(input logic [31:0] ins, input logic [7:0] tag);
        int waitCnt;
        waitCnt = 0;
        @(negedge clk);
        inValid = 1'b1;
        inIns   = ins;
        inTag   = tag;
        #1;
        while (!aInReady && waitCnt < 50) begin
            @(negedge clk);
            #1;
            waitCnt++;
        end
        checkOutput("A.accept_timeout", 64'(waitCnt >= 50), 64'd0);
        @(posedge clk);
        #1;
        inValid = 1'b0;
    endtask

    logic [31:0] directed [12];

    initial begin
        checks     = 0;
        errors     = 0;
        cntA       = 16'd0;
        cntB       = 16'd0;
        rstN       = 1'b0;
        inValid    = 1'b0;
        inIns      = 32'd0;
        inTag      = 8'd0;
        wantReadyA = 1'b1;
        wantReadyB = 1'b1;
        randReady  = 1'b0;
        directed = '{32'hFFF00093, 32'hFE000EE3, 32'h00509093, 32'h800000B7,
                     32'h00000000, 32'h02A0A223, 32'h12345037, 32'h00B50533,
                     32'h00C58567, 32'h00000073, 32'h02509093, 32'hFFDFF06F};

        repeat (3) @(negedge clk);
        rstN = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 12; i++) applyStimulus(directed[i], 8'(i + 16));
        repeat (4) @(negedge clk);

        // Stalled output: two entries fill the stage, the third waits.
        wantReadyA = 1'b0;
        applyStimulus(32'h00100093, 8'd1);
        applyStimulus(32'h00200093, 8'd2);
        fork
            begin
                repeat (4) @(negedge clk);
                wantReadyA = 1'b1;
            end
        join_none
        applyStimulus(32'h00300093, 8'd3);
        repeat (6) @(negedge clk);

        // Counter saturation from a preset value one below the ceiling.
        @(negedge clk);
        force dutA.r_illegal_cnt = 16'hFFFE;
        cntA = 16'hFFFE;
        #2;
        release dutA.r_illegal_cnt;
        applyStimulus(32'h00000000, 8'h51);
        applyStimulus(32'h0000007F, 8'h52);
        applyStimulus(32'h00000000, 8'h53);
        repeat (4) @(negedge clk);

        randReady = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            applyStimulus(randIns(), 8'($urandom));
        end
        randReady = 1'b0;
        repeat (10) @(negedge clk);

        // Reset while the skid instance holds two entries.
        wantReadyA = 1'b0;
        wantReadyB = 1'b0;
        applyStimulus(32'h00000000, 8'hA1);
        applyStimulus(32'hFFF00093, 8'hA2);
        @(negedge clk);
        rstN = 1'b0;
        @(negedge clk);
        rstN       = 1'b1;
        wantReadyA = 1'b1;
        wantReadyB = 1'b1;
        repeat (5) @(negedge clk);
        applyStimulus(32'hFE000EE3, 8'hA3);
        repeat (5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
